// File: rtl/led_string_monitor.sv
// led_string_monitor
//   Passive monitor for a single-wire, pulse-width-coded LED data line.
//   The line is asynchronous, so it is brought into the clk domain first.
//   High pulses are timed: short ones decode as 0, long ones as 1. Every
//   24 bits form one pixel. A long low gap (latch) ends a frame.
//   Malformed pulses are reported: too short (glitch) or too long (stuck).
//
// Ports
//   clk          : single clock for the whole block
//   reset_n      : synchronous, active-low reset
//   led_sdi      : asynchronous serial LED data line being monitored
//   pixel_data   : last decoded pixel, first-received bit in bit 23
//   pixel_valid  : one-cycle strobe qualifying pixel_data / pixel_index
//   pixel_index  : zero-based position of that pixel within its frame
//   frame_done   : one-cycle strobe at each latch gap that closes a frame
//   frame_pixels : complete pixels in the closed frame, valid with frame_done
//   glitch_err   : one-cycle strobe for a high pulse shorter than MIN_HIGH
//   stuck_err    : one-cycle strobe when a high pulse reaches MAX_HIGH
//   partial_err  : one-cycle strobe when a latch gap finds 1-23 bits pending
module led_string_monitor #(
    parameter int BIT_THRESH   = 12,
    parameter int MIN_HIGH     = 4,
    parameter int MAX_HIGH     = 40,
    parameter int LATCH_CYCLES = 1000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        led_sdi,
    output logic [23:0] pixel_data,
    output logic        pixel_valid,
    output logic [15:0] pixel_index,
    output logic        frame_done,
    output logic [15:0] frame_pixels,
    output logic        glitch_err,
    output logic        stuck_err,
    output logic        partial_err
);

    localparam int HW = $clog2(MAX_HIGH + 1);
    localparam int LW = $clog2(LATCH_CYCLES + 1);

    localparam logic [HW-1:0] HIGH_ONE = HW'(1);
    localparam logic [HW-1:0] HIGH_ZERO = HW'(0);
    localparam logic [HW-1:0] BIT_TH   = HW'(BIT_THRESH);
    localparam logic [HW-1:0] MIN_H    = HW'(MIN_HIGH);
    localparam logic [HW-1:0] MAX_M1   = HW'(MAX_HIGH - 1);
    localparam logic [LW-1:0] LOW_ZERO = LW'(0);
    localparam logic [LW-1:0] LOW_ONE  = LW'(1);
    localparam logic [LW-1:0] LATCH_V  = LW'(LATCH_CYCLES);
    localparam logic [LW-1:0] LATCH_M1 = LW'(LATCH_CYCLES - 1);

    typedef enum logic [2:0] {
        SYNC_WAIT = 3'd0,
        IDLE      = 3'd1,
        HIGH      = 3'd2,
        LOW       = 3'd3,
        ERR       = 3'd4
    } state_t;

    // Synchronizer, delayed copy and registered edge flags
    logic sync1_r, sync2_r, line_r, rise_r, fall_r;

    // FSM state and datapath registers
    state_t      state_r, state_s;
    logic [HW-1:0] high_cnt_r, high_cnt_s;
    logic [LW-1:0] low_cnt_r, low_cnt_s;
    logic [23:0] shift_r, shift_s;
    logic [4:0]  bit_cnt_r, bit_cnt_s;
    logic [15:0] pix_cnt_r, pix_cnt_s, pix_inc_s;
    logic        bit_s;

    // Event stage between the FSM and the output registers
    logic        ev_pix_r, ev_pix_s;
    logic        ev_frame_r, ev_frame_s;
    logic        ev_glitch_r, ev_glitch_s;
    logic        ev_stuck_r, ev_stuck_s;
    logic        ev_partial_r, ev_partial_s;
    logic [23:0] word_r, word_s;
    logic [15:0] idx_r, idx_s;
    logic [15:0] frm_cnt_r, frm_cnt_s;

    // Pixel counter saturates rather than wrapping on very long strings
    assign pix_inc_s = (pix_cnt_r == 16'hFFFF) ? pix_cnt_r : pix_cnt_r + 16'd1;

    // Two-flop synchronizer, one more stage, and registered edges; line_r is
    // the level that goes with rise_r/fall_r in the same cycle
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
            line_r  <= 1'b0;
            rise_r  <= 1'b0;
            fall_r  <= 1'b0;
        end else begin
            sync1_r <= led_sdi;
            sync2_r <= sync1_r;
            line_r  <= sync2_r;
            rise_r  <= sync2_r & ~line_r;
            fall_r  <= ~sync2_r & line_r;
        end
    end

    // FSM state and datapath register update
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_r      <= SYNC_WAIT;
            high_cnt_r   <= HIGH_ZERO;
            low_cnt_r    <= LOW_ZERO;
            shift_r      <= 24'd0;
            bit_cnt_r    <= 5'd0;
            pix_cnt_r    <= 16'd0;
            ev_pix_r     <= 1'b0;
            ev_frame_r   <= 1'b0;
            ev_glitch_r  <= 1'b0;
            ev_stuck_r   <= 1'b0;
            ev_partial_r <= 1'b0;
            word_r       <= 24'd0;
            idx_r        <= 16'd0;
            frm_cnt_r    <= 16'd0;
        end else begin
            state_r      <= state_s;
            high_cnt_r   <= high_cnt_s;
            low_cnt_r    <= low_cnt_s;
            shift_r      <= shift_s;
            bit_cnt_r    <= bit_cnt_s;
            pix_cnt_r    <= pix_cnt_s;
            ev_pix_r     <= ev_pix_s;
            ev_frame_r   <= ev_frame_s;
            ev_glitch_r  <= ev_glitch_s;
            ev_stuck_r   <= ev_stuck_s;
            ev_partial_r <= ev_partial_s;
            word_r       <= word_s;
            idx_r        <= idx_s;
            frm_cnt_r    <= frm_cnt_s;
        end
    end

    // Next-state, pulse timing, bit decode, pixel/frame bookkeeping
    always_comb begin
        state_s      = state_r;
        high_cnt_s   = high_cnt_r;
        low_cnt_s    = low_cnt_r;
        shift_s      = shift_r;
        bit_cnt_s    = bit_cnt_r;
        pix_cnt_s    = pix_cnt_r;
        bit_s        = 1'b0;
        ev_pix_s     = 1'b0;
        ev_frame_s   = 1'b0;
        ev_glitch_s  = 1'b0;
        ev_stuck_s   = 1'b0;
        ev_partial_s = 1'b0;
        word_s       = word_r;
        idx_s        = idx_r;
        frm_cnt_s    = frm_cnt_r;

        case (state_r)
            // Both wait for one clean latch gap; any high time restarts it
            SYNC_WAIT, ERR: begin
                if (line_r) begin
                    low_cnt_s = LOW_ZERO;
                end else if (low_cnt_r >= LATCH_M1) begin
                    low_cnt_s = LATCH_V;
                    state_s   = IDLE;
                end else begin
                    low_cnt_s = low_cnt_r + LOW_ONE;
                end
            end

            IDLE, LOW: begin
                if (rise_r) begin
                    state_s    = HIGH;
                    high_cnt_s = HIGH_ONE;
                    low_cnt_s  = LOW_ZERO;
                end else if (low_cnt_r == LATCH_M1) begin
                    // Latch gap: close the frame only if anything arrived
                    low_cnt_s = LATCH_V;
                    state_s   = IDLE;
                    if ((bit_cnt_r != 5'd0) || (pix_cnt_r != 16'd0)) begin
                        ev_frame_s   = 1'b1;
                        frm_cnt_s    = pix_cnt_r;
                        ev_partial_s = (bit_cnt_r != 5'd0);
                    end else begin
                        ev_frame_s = 1'b0;
                    end
                    bit_cnt_s = 5'd0;
                    pix_cnt_s = 16'd0;
                    shift_s   = 24'd0;
                end else if (low_cnt_r < LATCH_V) begin
                    low_cnt_s = low_cnt_r + LOW_ONE;
                end else begin
                    low_cnt_s = LATCH_V;
                end
            end

            HIGH: begin
                if (fall_r) begin
                    // The falling-edge cycle is the first low cycle
                    low_cnt_s = LOW_ONE;
                    if (high_cnt_r < MIN_H) begin
                        ev_glitch_s = 1'b1;
                        state_s     = (bit_cnt_r == 5'd0) ? IDLE : LOW;
                    end else begin
                        bit_s   = (high_cnt_r >= BIT_TH);
                        shift_s = {shift_r[22:0], bit_s};
                        state_s = LOW;
                        if (bit_cnt_r == 5'd23) begin
                            ev_pix_s  = 1'b1;
                            word_s    = {shift_r[22:0], bit_s};
                            idx_s     = pix_cnt_r;
                            pix_cnt_s = pix_inc_s;
                            bit_cnt_s = 5'd0;
                        end else begin
                            bit_cnt_s = bit_cnt_r + 5'd1;
                        end
                    end
                end else if (high_cnt_r >= MAX_M1) begin
                    // This cycle takes the count to MAX_HIGH
                    ev_stuck_s = 1'b1;
                    state_s    = ERR;
                    high_cnt_s = HIGH_ZERO;
                    low_cnt_s  = LOW_ZERO;
                    bit_cnt_s  = 5'd0;
                    shift_s    = 24'd0;
                    pix_cnt_s  = 16'd0;
                end else begin
                    high_cnt_s = high_cnt_r + HIGH_ONE;
                end
            end

            default: begin
                state_s = SYNC_WAIT;
            end
        endcase
    end

    // Output registers; data/index/count hold between strobes
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pixel_data   <= 24'd0;
            pixel_valid  <= 1'b0;
            pixel_index  <= 16'd0;
            frame_done   <= 1'b0;
            frame_pixels <= 16'd0;
            glitch_err   <= 1'b0;
            stuck_err    <= 1'b0;
            partial_err  <= 1'b0;
        end else begin
            pixel_data   <= word_r;
            pixel_valid  <= ev_pix_r;
            pixel_index  <= idx_r;
            frame_done   <= ev_frame_r;
            frame_pixels <= frm_cnt_r;
            glitch_err   <= ev_glitch_r;
            stuck_err    <= ev_stuck_r;
            partial_err  <= ev_partial_r;
        end
    end

endmodule

// File: doc/led_string_monitor.md
LED_STRING_MONITOR -- requirements
Module: led_string_monitor

Interface
REQ-001 SHALL have parameter BIT_THRESH, default 12: high-pulse length in clk cycles at or above which a bit decodes as 1.
REQ-002 SHALL have parameter MIN_HIGH, default 4: high pulses shorter than this are glitches.
REQ-003 SHALL have parameter MAX_HIGH, default 40: high pulses reaching this length are stuck-high errors.
REQ-004 SHALL have parameter LATCH_CYCLES, default 1000: continuous low time that ends a frame (50 us at 20 MHz).
REQ-005 SHALL have port clk, input, 1: the single clock for the whole block (clk_20 domain).
REQ-006 SHALL have port reset_n, input, 1: reset, synchronous and active-low.
REQ-007 SHALL have port led_sdi, input, 1: asynchronous serial LED data line being monitored.
REQ-008 SHALL have port pixel_data, output, 24: last decoded pixel, first-received bit in bit 23.
REQ-009 SHALL have port pixel_valid, output, 1: one-cycle strobe qualifying pixel_data and pixel_index.
REQ-010 SHALL have port pixel_index, output, 16: zero-based position of the pixel within its frame.
REQ-011 SHALL have port frame_done, output, 1: one-cycle strobe at each latch gap.
REQ-012 SHALL have port frame_pixels, output, 16: count of complete pixels in the frame, valid with frame_done.
REQ-013 SHALL have port glitch_err, output, 1: one-cycle strobe when a high pulse is shorter than MIN_HIGH.
REQ-014 SHALL have port stuck_err, output, 1: one-cycle strobe when a high pulse reaches MAX_HIGH.
REQ-015 SHALL have port partial_err, output, 1: one-cycle strobe when a latch gap occurs with 1-23 bits pending.

Function
REQ-016 SHALL synchronize led_sdi through two flops, then register the result once more for edge detection.
REQ-017 SHALL implement states SYNC_WAIT, IDLE, HIGH, LOW and ERR.
REQ-018 SHALL wait in SYNC_WAIT until the line is low for LATCH_CYCLES, then enter IDLE without asserting frame_done.
REQ-019 SHALL, in IDLE or LOW, move to HIGH on a synchronized rising edge with high_cnt = 1.
REQ-020 SHALL, in HIGH, increment high_cnt by 1 each cycle the line stays high.
REQ-021 SHALL, in HIGH, on a falling edge decode bit = (high_cnt >= BIT_THRESH) when high_cnt >= MIN_HIGH, shift it in MSB-first, and enter LOW.
REQ-022 SHALL, in HIGH, on a falling edge with high_cnt < MIN_HIGH, pulse glitch_err, discard the pulse without changing the bit count, and return to LOW (IDLE if no bits are pending).
REQ-023 SHALL, when the 24th bit is decoded, register pixel_data, present pixel_index, pulse pixel_valid, clear the bit count, and increment the pixel count.
REQ-024 SHALL have pixel_valid high exactly 4 clk cycles after the first clk edge that samples the raw falling edge ending bit 24.
REQ-025 SHALL, in IDLE or LOW, count low cycles in a low_cnt that saturates at LATCH_CYCLES.
REQ-026 SHALL, when low_cnt reaches LATCH_CYCLES, go to IDLE and pulse frame_done with frame_pixels equal to the complete-pixel count.
REQ-027 SHALL, at the REQ-026 latch, also pulse partial_err if 1-23 bits are pending, then clear the bits, the pixel count and the pixel index.
REQ-028 SHALL, at the REQ-026 latch, emit frame_done with frame_pixels = 0 when the frame held no complete pixel but some bits.
REQ-029 SHALL NOT pulse frame_done when the line stays low in IDLE with no bits and no pixels since the previous latch.
REQ-030 SHALL, when high_cnt reaches MAX_HIGH, pulse stuck_err once, discard pending bits, clear the pixel count, and enter ERR.
REQ-031 SHALL leave ERR for IDLE only after a low time of LATCH_CYCLES, without pulsing frame_done.
REQ-032 SHALL saturate the pixel count and pixel_index at 16'hFFFF.
REQ-033 SHALL hold pixel_data between strobes.

Reset
REQ-034 SHALL, while reset_n = 0 at a clk edge, set state to SYNC_WAIT, clear all counters and synchronizer flops, and drive every output to 0.
REQ-035 SHALL abandon any partially received pixel or frame on reset, with no strobes.

Verification
REQ-036 SHALL verify: after the initial 1000-cycle low, send 24 bits of 0xA5C3F0 (1 = 16 high/9 low, 0 = 8 high/17 low) -> one pixel_valid, pixel_data = 0xA5C3F0, pixel_index = 0.
REQ-037 SHALL verify: send 3 pixels, then 1000 low cycles -> pixel_index 0, 1, 2, then frame_done with frame_pixels = 3; the next frame starts at index 0.
REQ-038 SHALL verify: 12-cycle and 11-cycle high pulses -> bits decode as 1 and 0; a 2-cycle pulse -> glitch_err and unchanged bit count.
REQ-039 SHALL verify: hold high for 40 cycles mid-pixel -> single stuck_err; no frame_done; after 1000 low cycles, the next pixel decodes at index 0.
REQ-040 SHALL verify: 10 bits, then 1000 low cycles -> partial_err and frame_done together, frame_pixels = 0.
REQ-041 SHALL verify: reset_n low for one cycle mid-pixel -> all outputs 0; pixels sent before the line has been low for 1000 cycles produce no pixel_valid.
